ins_buffer: RTL and testbench

//  Parametrised instruction buffer between fetch and decode.
//  - Queues up to DEPTH fetched instructions with their PCs.
//  - Presents the head entry already split into MIPS fields (opcode/funct/rs/rt/rd/shamt/im1/im2).
//  - Uses valid/ready handshakes on both sides; supports pipeline flush on branch/jump redirect.

---
 rtl/ibuf_pkg.sv | 44 ++++
 rtl/ins_buffer_if.sv | 58 +++++
 rtl/ins_fields.sv | 49 ++++
 rtl/ins_buffer.sv | 108 ++++++++++
 tb/tb_ins_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibuf_pkg.sv
// Package for the instruction buffer: MIPS field positions, the opcodes that
// take a zero-extended immediate, and the instruction word type.
// Optional feature macro used by the design: IBUF_IMMEXT_EN.
package ibuf_pkg;

    typedef logic [31:0] instr_t;

    // Bit positions of the MIPS instruction fields.
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IM1_HI   = 15;
    localparam int IM1_LO   = 0;
    localparam int IM2_HI   = 25;
    localparam int IM2_LO   = 0;

    // Field widths derived from the positions above.
    localparam int OPC_W   = OPC_HI - OPC_LO + 1;
    localparam int REG_W   = RS_HI - RS_LO + 1;
    localparam int SHAMT_W = SHAMT_HI - SHAMT_LO + 1;
    localparam int FUNCT_W = FUNCT_HI - FUNCT_LO + 1;
    localparam int IM1_W   = IM1_HI - IM1_LO + 1;
    localparam int IM2_W   = IM2_HI - IM2_LO + 1;

    // Logical immediates are zero-extended; everything else sign-extends.
    localparam logic [OPC_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI = 6'h0E;

    // True when the opcode's 16-bit immediate is zero-extended.
    function automatic logic imm_is_unsigned(input logic [OPC_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/ins_buffer_if.sv
// Fetch/decode handshake bundle for the instruction buffer.
// master: fetch + decode side (drives in_*, out_ready, flush).
// slave : the buffer itself.
// With IBUF_IMMEXT_EN defined the bundle also carries imm_ext.
interface ins_buffer_if #(
    parameter int PC_W = 32
) ();

    // Fetch side and redirect.
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ins;
    logic [PC_W-1:0] in_pc;

    // Decode side: head entry, already split into fields.
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [15:0]     im1;
    logic [25:0]     im2;
`ifdef IBUF_IMMEXT_EN
    logic [31:0]     imm_ext;
`endif

`ifdef IBUF_IMMEXT_EN
    modport master (
        output flush, in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  opcode, funct, rs, rt, rd, shamt, im1, im2, imm_ext
    );

    modport slave (
        input  flush, in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output opcode, funct, rs, rt, rd, shamt, im1, im2, imm_ext
    );
`else
    modport master (
        output flush, in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  opcode, funct, rs, rt, rd, shamt, im1, im2
    );

    modport slave (
        input  flush, in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output opcode, funct, rs, rt, rd, shamt, im1, im2
    );
`endif

endinterface

// File: rtl/ins_fields.sv
// Purely combinational MIPS field slicer for the buffer head.
// All outputs are forced to zero while valid is low, so decode never sees
// stale storage contents.
// With IBUF_IMMEXT_EN defined it also produces the extended immediate.
module ins_fields
    import ibuf_pkg::*;
(
    input  instr_t             ins,
    input  logic               valid,
    output logic [OPC_W-1:0]   opcode,
    output logic [FUNCT_W-1:0] funct,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [SHAMT_W-1:0] shamt,
    output logic [IM1_W-1:0]   im1,
    output logic [IM2_W-1:0]   im2
`ifdef IBUF_IMMEXT_EN
    ,
    output logic [31:0]        imm_ext
`endif
);

    // Gating the word once makes every field below zero while invalid.
    instr_t gated;

    assign gated  = valid ? ins : '0;

    assign opcode = gated[OPC_HI:OPC_LO];
    assign funct  = gated[FUNCT_HI:FUNCT_LO];
    assign rs     = gated[RS_HI:RS_LO];
    assign rt     = gated[RT_HI:RT_LO];
    assign rd     = gated[RD_HI:RD_LO];
    assign shamt  = gated[SHAMT_HI:SHAMT_LO];
    assign im1    = gated[IM1_HI:IM1_LO];
    assign im2    = gated[IM2_HI:IM2_LO];

`ifdef IBUF_IMMEXT_EN
    // Zero-extend for the logical immediates, sign-extend otherwise; a gated
    // (all-zero) word extends to zero either way.
    always_comb begin
        imm_ext = {{16{gated[IM1_HI]}}, gated[IM1_HI:IM1_LO]};
        if (imm_is_unsigned(gated[OPC_HI:OPC_LO])) begin
            imm_ext = {16'h0000, gated[IM1_HI:IM1_LO]};
        end
    end
`endif

endmodule

// File: rtl/ins_buffer.sv
// Instruction buffer between fetch and decode.
// A DEPTH-entry circular queue of (instruction, PC) pairs with valid/ready on
// both sides and a synchronous flush for branch/jump redirects. The head
// entry is presented already split into MIPS fields via ins_fields.
// No empty bypass: a pushed word becomes visible one cycle later, and
// in_ready depends only on registered state.
// Optional feature: define IBUF_IMMEXT_EN to add the imm_ext output.
module ins_buffer
    import ibuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ins_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage: instruction words and their PCs.
    instr_t          mem_ins [DEPTH];
    logic [PC_W-1:0] mem_pc  [DEPTH];

    // Queue state.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic push;
    logic pop;
    logic head_valid;

    // Handshake status comes only from the registered count.
    assign head_valid    = (count != '0);
    assign bus.out_valid = head_valid;
    assign bus.in_ready  = (count != FULL_CNT);

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = head_valid    & bus.out_ready;

    // Occupancy update: push only grows, pop only shrinks, both together hold.
    always_comb begin
        // NOTE: default assigned first so every path drives count_next and no latch is inferred.
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and count registers; flush outranks any push/pop this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Storage write on an accepted push; a flushed push is dropped.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; outputs are gated by out_valid, so its contents never leak.
        if (push && !bus.flush) begin
            mem_ins[wr_ptr] <= bus.in_ins;
            mem_pc[wr_ptr]  <= bus.in_pc;
        end
    end

    // Head PC, zeroed while the buffer is empty.
    assign bus.out_pc = head_valid ? mem_pc[rd_ptr] : '0;

    // Field decode of the head instruction.
    ins_fields u_fields (
        .ins     (mem_ins[rd_ptr]),
        .valid   (head_valid),
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .shamt   (bus.shamt),
        .im1     (bus.im1),
        .im2     (bus.im2)
`ifdef IBUF_IMMEXT_EN
        ,
        .imm_ext (bus.imm_ext)
`endif
    );

endmodule

// File: tb/tb_ins_buffer.sv
// Self-checking bench for ins_buffer (DEPTH=4, PC_W=32).
// A queue model of the buffer holds every accepted (instruction, PC) pair;
// each cycle the DUT handshake and head outputs are compared to the model.
// Define IBUF_IMMEXT_EN to also exercise imm_ext.
module tb_ins_buffer;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst_n;

    ins_buffer_if #(.PC_W(PC_W)) bus ();

    ins_buffer #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Expected head view: every field plus the PC, all zero when empty.
    function automatic logic [105:0] exp_head(input ent_t e, input bit v);
        logic [31:0] w;
        logic [31:0] p;
        w = v ? e.ins : 32'h0;
        p = v ? e.pc  : 32'h0;
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0],
                w[15:0], w[25:0], p};
    endfunction

    function automatic logic [105:0] dut_head();
        return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
                bus.im1, bus.im2, bus.out_pc};
    endfunction

`ifdef IBUF_IMMEXT_EN
    function automatic logic [31:0] exp_imm(input ent_t e, input bit v);
        logic [5:0] op;
        op = e.ins[31:26];
        if (!v) return 32'h0;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0, e.ins[15:0]};
        return {{16{e.ins[15]}}, e.ins[15:0]};
    endfunction
`endif

    // One clock cycle: drive inputs, compare DUT against the model before the
    // edge, then advance the model the way the buffer should have moved.
    task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit   m_full;
        bit   m_valid;
        bit   do_push;
        bit   do_pop;
        ent_t head;
        ent_t nw;
        bus.in_valid  = v;
        bus.in_ins    = ins;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #3;
        m_full  = (sb.size() == DEPTH);
        m_valid = (sb.size() != 0);
        head    = m_valid ? sb[0] : '0;
        checks++;
        if (bus.in_ready !== !m_full) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (entries=%0d)", bus.in_ready, !m_full, sb.size());
        end
        checks++;
        if (bus.out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b (entries=%0d)", bus.out_valid, m_valid, sb.size());
        end
        checks++;
        if (dut_head() !== exp_head(head, m_valid)) begin
            errors++;
            $display("FAIL head: got %h expected %h", dut_head(), exp_head(head, m_valid));
        end
`ifdef IBUF_IMMEXT_EN
        checks++;
        if (bus.imm_ext !== exp_imm(head, m_valid)) begin
            errors++;
            $display("FAIL imm_ext: got %h expected %h", bus.imm_ext, exp_imm(head, m_valid));
        end
`endif
        do_push = v && !m_full && !fl;
        do_pop  = rdy && m_valid && !fl;
        nw.ins  = ins;
        nw.pc   = pc;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(nw);
        end
    endtask

    task automatic idle();
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ins    = 32'hDEADBEEF;
        bus.in_pc     = 32'h0000_1000;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (dut_head() !== 106'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", dut_head());
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        sb.delete();
        tick(1'b1, 32'h012A4020, 32'h0000_0100, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rs !== 5'd9 || bus.rt !== 5'd10 ||
            bus.rd !== 5'd8 || bus.funct !== 6'h20 || bus.out_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL first_push: got v=%b rs=%0d rt=%0d rd=%0d funct=%h pc=%h expected 1/9/10/8/20/00000100",
                     bus.out_valid, bus.rs, bus.rt, bus.rd, bus.funct, bus.out_pc);
        end
        drain();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++)
            tick(1'b1, 32'h2000_0000 + 32'(i * 32'h0001_0001), 32'h0000_0200 + 32'(4 * i), 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got in_ready=%b expected 0", bus.in_ready);
        end
        tick(1'b1, 32'hFFFF_FFFF, 32'h0000_0BAD, 1'b0, 1'b0);
        drain();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drained: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++)
            tick(1'b1, 32'h3C00_0000 | 32'(i), 32'h0000_0300 + 32'(4 * i), 1'b0, 1'b0);
        tick(1'b1, 32'h0BAD_0BAD, 32'h0000_0F00, 1'b1, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_frees: got in_ready=%b expected 1", bus.in_ready);
        end
        tick(1'b1, 32'h8C42_0010, 32'h0000_0310, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: got in_ready=%b expected 0", bus.in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            tick(1'b1, $urandom, 32'h0000_0400 + 32'(4 * i), 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            tick(1'b1, 32'h0100_0000 + 32'(i), 32'h0000_0500 + 32'(4 * i), 1'b0, 1'b0);
        tick(1'b1, 32'h0777_7777, 32'h0000_0600, 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dut_head() !== 106'h0) begin
            errors++;
            $display("FAIL flush: got out_valid=%b in_ready=%b head=%h expected 0/1/0",
                     bus.out_valid, bus.in_ready, dut_head());
        end
        idle();
        tick(1'b1, 32'h2108_0001, 32'h0000_0700, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        tick(1'b1, 32'h8D28_0004, 32'h0000_0800, 1'b0, 1'b0);
        tick(1'b1, 32'hAD28_0008, 32'h0000_0804, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        checks++;
        if (bus.out_pc !== 32'h0000_0800 || bus.opcode !== 6'h23 || bus.im1 !== 16'h0004) begin
            errors++;
            $display("FAIL backpressure_hold: got pc=%h op=%h im1=%h expected 00000800/23/0004",
                     bus.out_pc, bus.opcode, bus.im1);
        end
        drain();
    endtask

    task automatic test_async_reset();
        tick(1'b1, 32'h0000_0000, 32'h0000_0900, 1'b0, 1'b0);
        tick(1'b1, 32'h1000_FFFF, 32'h0000_0904, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dut_head() !== 106'h0) begin
            errors++;
            $display("FAIL async_reset: got out_valid=%b in_ready=%b head=%h expected 0/1/0",
                     bus.out_valid, bus.in_ready, dut_head());
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 32'h0043_2025, 32'h0000_0A00, 1'b0, 1'b0);
        drain();
    endtask

`ifdef IBUF_IMMEXT_EN
    task automatic test_immext();
        tick(1'b1, 32'h3108FFFF, 32'h0000_0B00, 1'b0, 1'b0);
        checks++;
        if (bus.imm_ext !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL immext_andi: got %h expected 0000ffff", bus.imm_ext);
        end
        tick(1'b1, 32'h2108FFFF, 32'h0000_0B04, 1'b1, 1'b0);
        checks++;
        if (bus.imm_ext !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL immext_addi: got %h expected ffffffff", bus.imm_ext);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_full_simul();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_async_reset();
`ifdef IBUF_IMMEXT_EN
        test_immext();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
